// File: rtl/rv_dmem_responder_if.sv
// Load/store bus between the RV32I core (master) and the data-memory responder (slave).
//   mem_read/mem_write : request strobes, held by the master until mem_resp
//   mem_funct3         : load_funct3_t / store_funct3_t encoding
//   mem_addr           : byte address
//   mem_wdata          : right-aligned store data
//   mem_rdata          : extended load data, valid with mem_resp
//   mem_resp/mem_err   : one-cycle completion pulse and its reject qualifier
interface rv_dmem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        mem_err;

  modport master (
    output mem_read, mem_write, mem_funct3, mem_addr, mem_wdata,
    input  mem_rdata, mem_resp, mem_err
  );

  modport slave (
    input  mem_read, mem_write, mem_funct3, mem_addr, mem_wdata,
    output mem_rdata, mem_resp, mem_err
  );
endinterface

// File: rtl/rv_dmem_responder.sv
// Data-memory responder: target end of the RV32I load/store interface, backed by on-chip SRAM.
// Accepts one access at a time, completes it with a single-cycle mem_resp LATENCY cycles later.
//   clk  : clock, rising edge
//   rst  : synchronous reset, active-high (SRAM contents are not reset)
//   bus  : rv_dmem_responder_if.slave (request in, mem_rdata/mem_resp/mem_err out)
// Optional feature: define MISALIGN_CHECK_EN to reject misaligned half/word accesses.
module rv_dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic               clk,
  input  logic               rst,
  rv_dmem_responder_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = (LATENCY < 2) ? 1 : $clog2(LATENCY);
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rd_q, wr_q;
  logic [2:0]      f3_q;
  logic [AW+1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic            resp_q, resp_d;
  logic            err_q, err_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            accept, commit, mem_we;

  logic [31:0]     mem [DEPTH_WORDS];

  // Operand source: live bus while idle (LATENCY=1 commits on the accept edge), latched copy after
  logic            cur_rd, cur_wr;
  logic [2:0]      cur_f3;
  logic [AW+1:0]   cur_addr;
  logic [31:0]     cur_wdata;
  logic            unused_addr_hi;

  assign cur_rd    = (state_q == IDLE) ? bus.mem_read            : rd_q;
  assign cur_wr    = (state_q == IDLE) ? bus.mem_write           : wr_q;
  assign cur_f3    = (state_q == IDLE) ? bus.mem_funct3          : f3_q;
  assign cur_addr  = (state_q == IDLE) ? bus.mem_addr[AW+1:0]    : addr_q;
  assign cur_wdata = (state_q == IDLE) ? bus.mem_wdata           : wdata_q;

  // Upper address bits alias onto the array
  assign unused_addr_hi = ^bus.mem_addr[31:AW+2];

  logic [AW-1:0]   idx;
  logic [31:0]     word;
  assign idx  = cur_addr[AW+1:2];
  assign word = mem[idx];

  // Access legality
  logic illegal, misalign, acc_err;
  always_comb begin
    illegal  = 1'b0;
    misalign = 1'b0;
    if (cur_wr) begin
      illegal = cur_f3[2] | (cur_f3[1:0] == 2'b11);
    end else begin
      illegal = (cur_f3 == 3'b011) | (cur_f3[2:1] == 2'b11);
    end
`ifdef MISALIGN_CHECK_EN
    case (cur_f3[1:0])
      2'b01:   misalign = cur_addr[0];
      2'b10:   misalign = |cur_addr[1:0];
      default: misalign = 1'b0;
    endcase
`else
    misalign = 1'b0;
`endif
    acc_err = (cur_rd & cur_wr) | illegal | misalign;
  end

  // Load extraction and store lane steering
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_v;
  logic [3:0]  be;
  logic [31:0] wd;
  always_comb begin
    byte_v = 8'(word >> {cur_addr[1:0], 3'b000});
    half_v = cur_addr[1] ? word[31:16] : word[15:0];
    case (cur_f3)
      3'b000:  load_v = {{24{byte_v[7]}}, byte_v};
      3'b100:  load_v = {24'h000000, byte_v};
      3'b001:  load_v = {{16{half_v[15]}}, half_v};
      3'b101:  load_v = {16'h0000, half_v};
      default: load_v = word;
    endcase
    case (cur_f3[1:0])
      2'b00: begin
        be = 4'b0001 << cur_addr[1:0];
        wd = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        be = cur_addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{cur_wdata[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = cur_wdata;
      end
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mem_read | bus.mem_write) begin
          accept = 1'b1;
          cnt_d  = CNT_INIT;
          if (LATENCY == 1) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == CW'(1)) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = CW'(cnt_q - CW'(1));
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    resp_d  = commit;
    err_d   = commit & acc_err;
    rdata_d = rdata_q;
    if (commit) begin
      if (acc_err)     rdata_d = 32'h0;
      else if (cur_rd) rdata_d = load_v;
    end
    mem_we = commit & cur_wr & ~acc_err & ~rst;
  end

  // State, request latch and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      resp_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      if (accept) begin
        rd_q    <= bus.mem_read;
        wr_q    <= bus.mem_write;
        f3_q    <= bus.mem_funct3;
        addr_q  <= bus.mem_addr[AW+1:0];
        wdata_q <= bus.mem_wdata;
      end
    end
  end

  // SRAM byte-lane write, committed on the edge entering RESP
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  assign bus.mem_resp  = resp_q;
  assign bus.mem_err   = err_q;
  assign bus.mem_rdata = rdata_q;

endmodule

// File: tb/tb_rv_dmem_responder.sv
// Self-checking bench for rv_dmem_responder: reference memory model, per-cycle output compare,
// literal checks of the documented scenarios, and resp-timing checks at LATENCY 1 and 4.
module tb_rv_dmem_responder;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned LAT   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  rv_dmem_responder_if u_if ();
  rv_dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model
  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_rdata = 32'h0;
  bit          pend_valid  = 1'b0;
  int unsigned pend_at     = 0;
  logic        pend_err;
  logic [31:0] pend_rdata;
  bit          cmp_en = 1'b0;
  bit          exp_resp, exp_err;

  function automatic void model_access(input bit rd, input bit wr, input logic [2:0] f3,
                                       input logic [31:0] addr, input logic [31:0] wdata,
                                       output logic err, output logic [31:0] rdata_after);
    int unsigned i   = (addr / 4) % DEPTH;
    int unsigned off = addr % 4;
    int unsigned f   = f3;
    logic [7:0]  b;
    logic [15:0] h;
    err = rd && wr;
    if (rd && !wr && (f == 3 || f == 6 || f == 7)) err = 1'b1;
    if (wr && !rd && f > 2) err = 1'b1;
`ifdef MISALIGN_CHECK_EN
    if (f % 4 == 1 && off % 2 != 0) err = 1'b1;
    if (f % 4 == 2 && off != 0) err = 1'b1;
`endif
    rdata_after = model_rdata;
    if (err) begin
      rdata_after = 32'h0;
      return;
    end
    b = 8'(model_mem[i] >> (8 * off));
    h = 16'(model_mem[i] >> ((off >= 2) ? 16 : 0));
    if (rd) begin
      case (f)
        0:       rdata_after = 32'($signed(b));
        4:       rdata_after = 32'(b);
        1:       rdata_after = 32'($signed(h));
        5:       rdata_after = 32'(h);
        default: rdata_after = model_mem[i];
      endcase
    end else begin
      case (f)
        0:       model_mem[i][8*off +: 8] = wdata[7:0];
        1:       model_mem[i][((off >= 2) ? 16 : 0) +: 16] = wdata[15:0];
        default: model_mem[i] = wdata;
      endcase
    end
  endfunction

  // Caller is at posedge+1; returns at posedge+1 one idle cycle after the response
  task automatic issue(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] got_rdata, output logic got_err);
    u_if.mem_read   = rd;
    u_if.mem_write  = wr;
    u_if.mem_funct3 = f3;
    u_if.mem_addr   = addr;
    u_if.mem_wdata  = wdata;
    model_access(rd, wr, f3, addr, wdata, pend_err, pend_rdata);
    pend_at    = cyc + LAT;
    pend_valid = 1'b1;
    repeat (LAT) @(posedge clk);
    #1;
    got_rdata      = u_if.mem_rdata;
    got_err        = u_if.mem_err;
    u_if.mem_read  = 1'b0;
    u_if.mem_write = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Per-cycle compare of all outputs against the model
  always @(negedge clk) begin
    if (rst) begin
      model_rdata = 32'h0;
      pend_valid  = 1'b0;
    end else if (cmp_en) begin
      exp_resp = pend_valid && (cyc == pend_at);
      exp_err  = exp_resp ? pend_err : 1'b0;
      if (exp_resp) begin
        model_rdata = pend_rdata;
        pend_valid  = 1'b0;
      end
      chk("mem_resp", 32'(u_if.mem_resp), 32'(exp_resp));
      chk("mem_err", 32'(u_if.mem_err), 32'(exp_err));
      chk("mem_rdata", u_if.mem_rdata, model_rdata);
    end
  end

  // Response timing at LATENCY 1 and 4
  for (genvar g = 0; g < 2; g++) begin : g_lat
    localparam int unsigned L = (g == 0) ? 1 : 4;
    rv_dmem_responder_if lif ();
    rv_dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(L)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (lif.slave)
    );
    bit done = 1'b0;
    initial begin
      int n;
      lif.mem_read = 1'b0; lif.mem_write = 1'b0;
      lif.mem_funct3 = 3'b000; lif.mem_addr = 32'h0; lif.mem_wdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      for (int op = 0; op < 2; op++) begin
        lif.mem_write  = (op == 0);
        lif.mem_read   = (op == 1);
        lif.mem_funct3 = 3'b010;
        lif.mem_addr   = 32'h10;
        lif.mem_wdata  = 32'hDEADBEEF;
        n = 0;
        for (int j = 1; j <= 10; j++) begin
          @(posedge clk);
          @(negedge clk);
          if (lif.mem_resp) begin
            n = j;
            break;
          end
        end
        chk($sformatf("lat%0d_resp_cycle", L), 32'(n), 32'(L));
        chk($sformatf("lat%0d_err", L), 32'(lif.mem_err), 32'h0);
        if (op == 1) chk($sformatf("lat%0d_lw", L), lif.mem_rdata, 32'hDEADBEEF);
        lif.mem_read  = 1'b0;
        lif.mem_write = 1'b0;
        @(negedge clk);
        chk($sformatf("lat%0d_pulse", L), 32'(lif.mem_resp), 32'h0);
        @(posedge clk);
        #1;
      end
      done = 1'b1;
    end
  end

  initial begin
    logic [31:0] rd_v;
    logic        er_v;
    int          r;
    logic [2:0]  f3;
    logic [2:0]  legal_ld [5];
    legal_ld = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    u_if.mem_read = 1'b0; u_if.mem_write = 1'b0;
    u_if.mem_funct3 = 3'b000; u_if.mem_addr = 32'h0; u_if.mem_wdata = 32'h0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_resp", 32'(u_if.mem_resp), 32'h0);
    chk("reset_err", 32'(u_if.mem_err), 32'h0);
    chk("reset_rdata", u_if.mem_rdata, 32'h0);
    cmp_en = 1'b1;

    // First request on the first cycle after reset
    issue(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, rd_v, er_v);
    chk("sw_err", 32'(er_v), 32'h0);
    for (int i = 0; i < DEPTH; i++)
      if (i != 4) issue(0, 1, 3'b010, 32'(4 * i), $urandom, rd_v, er_v);

    issue(1, 0, 3'b010, 32'h10, 32'h0, rd_v, er_v);
    chk("lw_deadbeef", rd_v, 32'hDEADBEEF);

    issue(0, 1, 3'b000, 32'h13, 32'h80, rd_v, er_v);
    issue(1, 0, 3'b000, 32'h13, 32'h0, rd_v, er_v);
    chk("lb_sign", rd_v, 32'hFFFFFF80);
    issue(1, 0, 3'b100, 32'h13, 32'h0, rd_v, er_v);
    chk("lbu_zero", rd_v, 32'h00000080);
    issue(1, 0, 3'b010, 32'h10, 32'h0, rd_v, er_v);
    chk("lw_after_sb", rd_v, 32'h80ADBEEF);

    issue(0, 1, 3'b001, 32'h12, 32'h1234, rd_v, er_v);
    issue(1, 0, 3'b010, 32'h10, 32'h0, rd_v, er_v);
    chk("lw_after_sh", rd_v, 32'h1234BEEF);
    issue(1, 0, 3'b001, 32'h10, 32'h0, rd_v, er_v);
    chk("lh_sign", rd_v, 32'hFFFFBEEF);
    issue(1, 0, 3'b101, 32'h10, 32'h0, rd_v, er_v);
    chk("lhu_zero", rd_v, 32'h0000BEEF);

    issue(1, 0, 3'b010, 32'h11, 32'h0, rd_v, er_v);
`ifdef MISALIGN_CHECK_EN
    chk("lw_mis_err", 32'(er_v), 32'h1);
    chk("lw_mis_rdata", rd_v, 32'h0);
    issue(0, 1, 3'b010, 32'h12, 32'h0, rd_v, er_v);
    chk("sw_mis_err", 32'(er_v), 32'h1);
    issue(1, 0, 3'b010, 32'h10, 32'h0, rd_v, er_v);
    chk("lw_after_mis_sw", rd_v, 32'h1234BEEF);
`else
    chk("lw_unaligned", rd_v, 32'h1234BEEF);
    chk("lw_unaligned_err", 32'(er_v), 32'h0);
    issue(0, 1, 3'b010, 32'h12, 32'h0, rd_v, er_v);
    chk("sw_unaligned_err", 32'(er_v), 32'h0);
    issue(1, 0, 3'b010, 32'h10, 32'h0, rd_v, er_v);
    chk("lw_after_unaligned_sw", rd_v, 32'h0);
`endif

    // Reset on the commit edge abandons the store
    issue(0, 1, 3'b010, 32'h10, 32'hCAFEF00D, rd_v, er_v);
    u_if.mem_write = 1'b1; u_if.mem_read = 1'b0;
    u_if.mem_funct3 = 3'b010; u_if.mem_addr = 32'h10; u_if.mem_wdata = 32'h0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    u_if.mem_write = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(1, 0, 3'b010, 32'h10, 32'h0, rd_v, er_v);
    chk("lw_after_abort", rd_v, 32'hCAFEF00D);

    issue(1, 1, 3'b010, 32'h10, 32'h5555AAAA, rd_v, er_v);
    chk("rw_both_err", 32'(er_v), 32'h1);
    chk("rw_both_rdata", rd_v, 32'h0);
    issue(1, 0, 3'b011, 32'h10, 32'h0, rd_v, er_v);
    chk("ld_f3_011_err", 32'(er_v), 32'h1);
    issue(1, 0, 3'b010, 32'h10 + 4 * DEPTH, 32'h0, rd_v, er_v);
    chk("alias_lw", rd_v, 32'hCAFEF00D);
    issue(0, 1, 3'b010, 32'h10 + 8 * DEPTH, 32'h0BADCAFE, rd_v, er_v);
    issue(1, 0, 3'b010, 32'h10, 32'h0, rd_v, er_v);
    chk("alias_sw", rd_v, 32'h0BADCAFE);

    // Randomized traffic, checked cycle by cycle against the model
    for (int k = 0; k < 400; k++) begin
      r  = $urandom_range(0, 15);
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 4) != 0) begin
        if (r >= 8) f3 = 3'($urandom_range(0, 2));
        else        f3 = legal_ld[$urandom_range(0, 4)];
      end
      issue(r < 8, r >= 8 || r == 0, f3, 32'($urandom_range(0, 16 * DEPTH - 1)), $urandom,
            rd_v, er_v);
    end

    for (int i = 0; i < 2000 && !(g_lat[0].done && g_lat[1].done); i++) @(posedge clk);
    chk("latency_benches_done", 32'(g_lat[0].done && g_lat[1].done), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
